// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch that counts one-second ticks, with start/stop, lap-freeze and clear control.
// The count either wraps at MAX_MIN:59 or saturates there, depending on WRAP.
module stopwatch_counter #(
   parameter bit WRAP    = 1'b1,
   parameter int MAX_MIN = 99
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic       run_en,
   output logic [3:0] disp_min_t,
   output logic [3:0] disp_min_o,
   output logic [3:0] disp_sec_t,
   output logic [3:0] disp_sec_o,
   output logic       lap_active,
   output logic       rollover,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   localparam logic [3:0]  MAX_T    = 4'(MAX_MIN / 10);
   localparam logic [3:0]  MAX_O    = 4'(MAX_MIN % 10);
   localparam logic [15:0] TERMINAL = {MAX_T, MAX_O, 4'd5, 4'd9};

   // Count packed as {min_t, min_o, sec_t, sec_o}; the terminal value is handled by the caller.
   function automatic logic [15:0] bcd_inc(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (c[3:0] != 4'd9) begin
         r[3:0] = c[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (c[7:4] != 4'd5) begin
            r[7:4] = c[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (c[11:8] != 4'd9) begin
               r[11:8] = c[11:8] + 4'd1;
            end else begin
               r[11:8]  = 4'd0;
               r[15:12] = c[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   state_t      state_r;
   state_t      next_state_s;
   logic [15:0] cnt_r;
   logic [15:0] cnt_next_s;
   logic [15:0] lap_r;
   logic        run_en_r;
   logic        rollover_r;
   logic        overflow_r;

   logic        counting_s;
   logic        tick_ok_s;
   logic        terminal_s;
   logic        saturate_s;
   logic        clear_s;
   logic        lap_latch_s;

   // Ticks are ignored once saturated, until clear.
   assign counting_s  = (state_r == RUN) || (state_r == LAP);
   assign tick_ok_s   = tick && counting_s && !overflow_r;
   assign terminal_s  = tick_ok_s && (cnt_r == TERMINAL);
   assign saturate_s  = terminal_s && (WRAP == 1'b0);
   assign clear_s     = (state_r == PAUSE) && !start_stop && clear;
   assign lap_latch_s = (state_r == RUN) && !start_stop && lap;

   // State register.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; button priority is start_stop > lap > clear.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_stop) next_state_s = RUN;
            else            next_state_s = IDLE;
         end
         RUN: begin
            if (start_stop || saturate_s) next_state_s = PAUSE;
            else if (lap)                 next_state_s = LAP;
            else                          next_state_s = RUN;
         end
         LAP: begin
            if (start_stop || saturate_s) next_state_s = PAUSE;
            else if (lap)                 next_state_s = RUN;
            else                          next_state_s = LAP;
         end
         PAUSE: begin
            if (start_stop) next_state_s = RUN;
            else if (clear) next_state_s = IDLE;
            else            next_state_s = PAUSE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Next live count: clear, wrap to zero, hold at terminal, or BCD increment.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear_s) begin
         cnt_next_s = 16'h0000;
      end else if (terminal_s) begin
         if (WRAP == 1'b1) cnt_next_s = 16'h0000;
         else              cnt_next_s = cnt_r;
      end else if (tick_ok_s) begin
         cnt_next_s = bcd_inc(cnt_r);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Live count, lap latch and status registers.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         cnt_r      <= 16'h0000;
         lap_r      <= 16'h0000;
         run_en_r   <= 1'b0;
         rollover_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         cnt_r      <= cnt_next_s;
         run_en_r   <= (next_state_s == RUN) || (next_state_s == LAP);
         rollover_r <= terminal_s && (WRAP == 1'b1);
         if (clear_s)          lap_r <= 16'h0000;
         else if (lap_latch_s) lap_r <= cnt_r;
         else                  lap_r <= lap_r;
         if (clear_s)         overflow_r <= 1'b0;
         else if (saturate_s) overflow_r <= 1'b1;
         else                 overflow_r <= overflow_r;
      end
   end

   // Output decode: the display shows the frozen lap value only while in LAP.
   always_comb begin
      run_en     = run_en_r;
      rollover   = rollover_r;
      overflow   = overflow_r;
      lap_active = (state_r == LAP);
      if (state_r == LAP) begin
         {disp_min_t, disp_min_o, disp_sec_t, disp_sec_o} = lap_r;
      end else begin
         {disp_min_t, disp_min_o, disp_sec_t, disp_sec_o} = cnt_r;
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a wrapping instance (a) and a saturating instance (b),
// expected status pushed to a scoreboard queue at stimulus time and popped after the DUT responds.
module tb_stopwatch_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       n_rst;
   logic       tick_a, ss_a, lap_a, clr_a;
   logic       tick_b, ss_b, lap_b, clr_b;
   logic       run_en_a, lap_active_a, rollover_a, overflow_a;
   logic       run_en_b, lap_active_b, rollover_b, overflow_b;
   logic [3:0] mt_a, mo_a, st_a, so_a;
   logic [3:0] mt_b, mo_b, st_b, so_b;

   stopwatch_counter #(.WRAP(1'b1), .MAX_MIN(99)) dut_a (
      .clk(clk), .n_rst(n_rst), .tick(tick_a), .start_stop(ss_a), .lap(lap_a), .clear(clr_a),
      .run_en(run_en_a), .disp_min_t(mt_a), .disp_min_o(mo_a), .disp_sec_t(st_a), .disp_sec_o(so_a),
      .lap_active(lap_active_a), .rollover(rollover_a), .overflow(overflow_a)
   );

   stopwatch_counter #(.WRAP(1'b0), .MAX_MIN(99)) dut_b (
      .clk(clk), .n_rst(n_rst), .tick(tick_b), .start_stop(ss_b), .lap(lap_b), .clear(clr_b),
      .run_en(run_en_b), .disp_min_t(mt_b), .disp_min_o(mo_b), .disp_sec_t(st_b), .disp_sec_o(so_b),
      .lap_active(lap_active_b), .rollover(rollover_b), .overflow(overflow_b)
   );

   typedef struct {
      string       tag;
      bit          sel;
      logic [19:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Status word: {run_en, lap_active, rollover, overflow, MM:SS}.
   function automatic logic [19:0] obs(input bit sel);
      if (sel) return {run_en_b, lap_active_b, rollover_b, overflow_b, mt_b, mo_b, st_b, so_b};
      else     return {run_en_a, lap_active_a, rollover_a, overflow_a, mt_a, mo_a, st_a, so_a};
   endfunction

   function automatic logic [19:0] stat(input bit r, input bit l, input bit ro, input bit ov,
                                        input logic [15:0] d);
      return {r, l, ro, ov, d};
   endfunction

   task automatic check_pop();
      exp_t        e;
      logic [19:0] o;
      e = sb.pop_front();
      o = obs(e.sel);
      n_chk++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
   endtask

   task automatic expect_now(input bit sel, input string tag, input logic [19:0] e);
      sb.push_back('{tag: tag, sel: sel, exp: e});
      check_pop();
   endtask

   task automatic step(input bit sel, input bit ss, input bit lp, input bit cl, input bit tk,
                       input bit chk, input string tag, input logic [19:0] e);
      if (chk) sb.push_back('{tag: tag, sel: sel, exp: e});
      if (sel) {ss_b, lap_b, clr_b, tick_b} = {ss, lp, cl, tk};
      else     {ss_a, lap_a, clr_a, tick_a} = {ss, lp, cl, tk};
      @(posedge clk);
      #1;
      {ss_a, lap_a, clr_a, tick_a, ss_b, lap_b, clr_b, tick_b} = 8'h00;
      if (chk) check_pop();
   endtask

   task automatic ticks(input bit sel, input int n);
      for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "", 20'h00000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      n_rst = 1'b1;
      {ss_a, lap_a, clr_a, tick_a, ss_b, lap_b, clr_b, tick_b} = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b0;
      expect_now(1'b0, "reset_a", stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      expect_now(1'b1, "reset_b", stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));

      // Idle ignores tick/lap/clear, then start and count 61 s.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "idle_tick",   stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "idle_lapclr", stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "start",       stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
      ticks(1'b0, 60);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "count_0101",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0101));

      // Pause, clear, restart; lap freeze.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pause",       stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0101));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "clear",       stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "", 20'h00000);
      ticks(1'b0, 36);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "count_0037",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0037));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "run_clr_ign", stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0037));
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "lap_freeze",  stat(1'b1, 1'b1, 1'b0, 1'b0, 16'h0037));
      ticks(1'b0, 4);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "lap_hold",    stat(1'b1, 1'b1, 1'b0, 1'b0, 16'h0037));
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "lap_exit",    stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0042));

      // start_stop with tick in RUN counts the tick; pause ignores ticks; clear to idle.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "", 20'h00000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "", 20'h00000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "", 20'h00000);
      ticks(1'b0, 8);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "count_0009",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "stop_tick",   stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010));
      ticks(1'b0, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "pause_tick",  stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "pause_clear", stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "start_tick",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));

      // All three buttons in RUN only pause; count to 12:34, then async reset.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "all_three",   stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "resume",      stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
      ticks(1'b0, 753);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "count_1234",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234));
      #2;
      n_rst = 1'b1;
      #1;
      expect_now(1'b0, "async_rst",                           stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      @(posedge clk);
      #1;
      n_rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst",    stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));

      // Wrapping instance: 99:59 -> 00:00 with a one-cycle rollover pulse.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "", 20'h00000);
      ticks(1'b0, 5998);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "a_9959",      stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h9959));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "wrap",        stat(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "wrap_after",  stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001));

      // Saturating instance: hold 99:59, sticky overflow, pause; clear recovers.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "", 20'h00000);
      ticks(1'b1, 5998);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "b_9959",      stat(1'b1, 1'b0, 1'b0, 1'b0, 16'h9959));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "saturate",    stat(1'b0, 1'b0, 1'b0, 1'b1, 16'h9959));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "sat_hold",    stat(1'b0, 1'b0, 1'b0, 1'b1, 16'h9959));
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "ovf_clear",   stat(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
